mips_trace_tx: RTL and testbench

Hardware trace transmitter for the MIPS core: accepts one (pc, ir) record per retired instruction, buffers records in a small FIFO, and streams them as ASCII over an 8N1 UART line in the same `pc=XXXXXXXX ir=XXXXXXXX` format the simulation top prints. It applies the simulation halt rule in hardware: six consecutive NOPs or a misaligned pc. On halt it emits `halt!` and stops accepting records. It sits beside `PROCESSOR` on the FPGA top, tapping its pc/ir.

---
 rtl/mips_trace_tx.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mips_trace_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_tx.sv
// Trace transmitter: buffers retired (pc, ir) records and streams them as ASCII over an 8N1 UART.
// Define MIPS_TRACE_CYCLE_EN to append the frozen cycle count after the halt message.
module mips_trace_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16,
    parameter int NOP_LIMIT  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_ir,
    output logic        uart_txd,
    output logic        halt,
    output logic        done,
    output logic        overflow,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int NW = $clog2(NOP_LIMIT + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_NEXT      = 3'd3;
    localparam logic [2:0] ST_HALT_MSG  = 3'd4;
    localparam logic [2:0] ST_CYCLE_MSG = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam logic [1:0] MSG_REC  = 2'd0;
    localparam logic [1:0] MSG_HALT = 2'd1;
    localparam logic [1:0] MSG_CYC  = 2'd2;

    function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] k);
        logic [3:0] nib;
        nib = 4'(w >> {3'd7 - k, 2'b00});
        if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
        else             hex_char = 8'h57 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] char_at(input logic [1:0] msg, input logic [4:0] idx,
                                           input logic [63:0] rec, input logic [31:0] cyc);
        char_at = 8'h20;
        case (msg)
            MSG_REC: begin
                if (idx >= 5'd3 && idx <= 5'd10)
                    char_at = hex_char(rec[63:32], idx[2:0] - 3'd3);
                else if (idx >= 5'd15 && idx <= 5'd22)
                    char_at = hex_char(rec[31:0], idx[2:0] + 3'd1);
                else begin
                    case (idx)
                        5'd0:         char_at = 8'h70;
                        5'd1:         char_at = 8'h63;
                        5'd2, 5'd14:  char_at = 8'h3d;
                        5'd12:        char_at = 8'h69;
                        5'd13:        char_at = 8'h72;
                        5'd23:        char_at = 8'h0d;
                        5'd24:        char_at = 8'h0a;
                        default:      char_at = 8'h20;
                    endcase
                end
            end
            MSG_HALT: begin
                case (idx)
                    5'd0:    char_at = 8'h68;
                    5'd1:    char_at = 8'h61;
                    5'd2:    char_at = 8'h6c;
                    5'd3:    char_at = 8'h74;
                    5'd4:    char_at = 8'h21;
                    5'd5:    char_at = 8'h0d;
                    default: char_at = 8'h0a;
                endcase
            end
            MSG_CYC: begin
                if (idx >= 5'd6 && idx <= 5'd13)
                    char_at = hex_char(cyc, idx[2:0] - 3'd6);
                else begin
                    case (idx)
                        5'd0:    char_at = 8'h63;
                        5'd1:    char_at = 8'h79;
                        5'd2:    char_at = 8'h63;
                        5'd3:    char_at = 8'h6c;
                        5'd4:    char_at = 8'h65;
                        5'd5:    char_at = 8'h3d;
                        5'd14:   char_at = 8'h0d;
                        default: char_at = 8'h0a;
                    endcase
                end
            end
            default: char_at = 8'h20;
        endcase
    endfunction

    logic [63:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_r;
    logic [NW-1:0]  nop_cnt_r, nop_next_s;
    logic           halt_r, done_r, overflow_r;
    logic [2:0]     state_r;
    logic [1:0]     msg_r;
    logic [4:0]     idx_r, last_idx_s;
    logic [63:0]    hold_r;
    logic           tx_busy_r, txd_r, tx_start_s, tx_end_s;
    logic [8:0]     tx_shift_r;
    logic [3:0]     tx_bit_r;
    logic [BW-1:0]  tx_baud_r;
    logic [7:0]     tx_char_s;
    logic [31:0]    cyc_s;
    logic           full_s, empty_s, accept_s, push_s, pop_s, trigger_s;

    assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign accept_s  = trace_valid && !halt_r;
    assign push_s    = accept_s && !full_s;
    assign pop_s     = (state_r == ST_LOAD);
    assign trigger_s = accept_s && ((nop_next_s == NW'(NOP_LIMIT)) || (trace_pc[1:0] != 2'b00));
    assign tx_end_s  = tx_busy_r && (tx_baud_r == BW'(BAUD_DIV - 1)) && (tx_bit_r == 4'd9);

`ifdef MIPS_TRACE_CYCLE_EN
    logic [31:0] cyc_r;
    // Free-running cycle count, frozen once halt is seen.
    always_ff @(posedge clk) begin
        if (rst)          cyc_r <= 32'h0;
        else if (!halt_r) cyc_r <= cyc_r + 32'd1;
    end
    assign cyc_s = cyc_r;
`else
    assign cyc_s = 32'h0;
`endif

    // Next NOP-run length for the record presented this cycle.
    always_comb begin
        nop_next_s = {NW{1'b0}};
        if (trace_ir == 32'h0) begin
            if (nop_cnt_r == NW'(NOP_LIMIT)) nop_next_s = nop_cnt_r;
            else                             nop_next_s = nop_cnt_r + NW'(1'b1);
        end else begin
            nop_next_s = {NW{1'b0}};
        end
    end

    // Record storage; the memory itself needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) mem_r[wr_ptr_r] <= {trace_pc, trace_ir};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            count_r <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        end
    end

    // Halt detection, NOP run tracking and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            nop_cnt_r  <= {NW{1'b0}};
            halt_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s)           nop_cnt_r  <= nop_next_s;
            if (trigger_s)          halt_r     <= 1'b1;
            if (accept_s && full_s) overflow_r <= 1'b1;
        end
    end

    always_comb begin
        case (msg_r)
            MSG_REC:  last_idx_s = 5'd24;
            MSG_HALT: last_idx_s = 5'd6;
            MSG_CYC:  last_idx_s = 5'd15;
            default:  last_idx_s = 5'd24;
        endcase
    end

    // Characters are launched on entry to SEND, so index 0 comes from the setup states.
    always_comb begin
        tx_start_s = 1'b0;
        tx_char_s  = 8'h00;
        case (state_r)
            ST_LOAD: begin
                tx_start_s = 1'b1;
                tx_char_s  = char_at(MSG_REC, 5'd0, hold_r, cyc_s);
            end
            ST_HALT_MSG: begin
                tx_start_s = 1'b1;
                tx_char_s  = char_at(MSG_HALT, 5'd0, hold_r, cyc_s);
            end
            ST_CYCLE_MSG: begin
                tx_start_s = 1'b1;
                tx_char_s  = char_at(MSG_CYC, 5'd0, hold_r, cyc_s);
            end
            ST_NEXT: begin
                if (idx_r != last_idx_s) begin
                    tx_start_s = 1'b1;
                    tx_char_s  = char_at(msg_r, idx_r + 5'd1, hold_r, cyc_s);
                end else begin
                    tx_start_s = 1'b0;
                end
            end
            default: tx_start_s = 1'b0;
        endcase
    end

    // Message sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            msg_r   <= MSG_REC;
            idx_r   <= 5'd0;
            hold_r  <= 64'h0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s)    state_r <= ST_LOAD;
                    else if (halt_r) state_r <= ST_HALT_MSG;
                end
                ST_LOAD: begin
                    hold_r  <= mem_r[rd_ptr_r];
                    msg_r   <= MSG_REC;
                    idx_r   <= 5'd0;
                    state_r <= ST_SEND;
                end
                ST_HALT_MSG: begin
                    msg_r   <= MSG_HALT;
                    idx_r   <= 5'd0;
                    state_r <= ST_SEND;
                end
                ST_CYCLE_MSG: begin
                    msg_r   <= MSG_CYC;
                    idx_r   <= 5'd0;
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_end_s) state_r <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx_r != last_idx_s) begin
                        idx_r   <= idx_r + 5'd1;
                        state_r <= ST_SEND;
                    end else if (msg_r == MSG_REC) begin
                        state_r <= ST_IDLE;
`ifdef MIPS_TRACE_CYCLE_EN
                    end else if (msg_r == MSG_HALT) begin
                        state_r <= ST_CYCLE_MSG;
`endif
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // 8N1 serializer: start bit, LSB-first data, stop bit, BAUD_DIV cycles each.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_r      <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_shift_r <= 9'h1ff;
            tx_bit_r   <= 4'd0;
            tx_baud_r  <= {BW{1'b0}};
        end else if (tx_start_s) begin
            txd_r      <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_shift_r <= {1'b1, tx_char_s};
            tx_bit_r   <= 4'd0;
            tx_baud_r  <= {BW{1'b0}};
        end else if (tx_busy_r) begin
            if (tx_baud_r == BW'(BAUD_DIV - 1)) begin
                tx_baud_r <= {BW{1'b0}};
                if (tx_bit_r == 4'd9) begin
                    tx_busy_r <= 1'b0;
                end else begin
                    txd_r      <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                    tx_bit_r   <= tx_bit_r + 4'd1;
                end
            end else begin
                tx_baud_r <= tx_baud_r + BW'(1'b1);
            end
        end
    end

    assign uart_txd = txd_r;
    assign halt     = halt_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign busy     = !empty_s || ((state_r != ST_IDLE) && (state_r != ST_DONE));

endmodule

// File: tb/tb_mips_trace_tx.sv
// Directed bench for mips_trace_tx: decodes the UART line and checks text, flags and timing.
module tb_mips_trace_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_pc = 32'h0;
    logic [31:0] trace_ir = 32'h0;
    logic        uart_txd, halt, done, overflow, busy;

    int tests = 0;
    int fails = 0;
    int n;
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;

    mips_trace_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .NOP_LIMIT(6)) dut (
        .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_ir(trace_ir), .uart_txd(uart_txd), .halt(halt), .done(done),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // UART receiver: samples near mid-bit on falling clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_txd === 1'b0) begin
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    rx_byte[i] = uart_txd;
                end
                repeat (BAUD) @(negedge clk);
                rx_q.push_back(rx_byte);
            end
        end
    end

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0d)      r = {r, "~"};
            else if (s[i] == 8'h0a) r = {r, "|"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic string rx_str(input int len);
        string s = "";
        for (int i = 0; i < len && i < rx_q.size(); i++) s = $sformatf("%s%c", s, rx_q[i]);
        return s;
    endfunction

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string got, input string exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(got), vis(exp));
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_ir    = ir;
        @(negedge clk);
        trace_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_bit(tag, busy, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_bit(tag, done, 1'b1);
    endtask

    initial begin
        string exp;

        // Reset state
        repeat (3) @(negedge clk);
        chk_bit("rst_txd", uart_txd, 1'b1);
        chk_bit("rst_halt", halt, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_overflow", overflow, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("idle_busy", busy, 1'b0);

        // Single record: start-bit latency, text and busy duration
        rx_q.delete();
        send(32'h00400010, 32'h8d080004);
        chk_bit("t1_busy_after_accept", busy, 1'b1);
        chk_bit("t1_txd_t0", uart_txd, 1'b1);
        @(negedge clk);
        chk_bit("t1_txd_t1", uart_txd, 1'b1);
        @(negedge clk);
        chk_bit("t1_start_bit_t2", uart_txd, 1'b0);
        n = 2;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_bit("t1_busy_window", (n >= 1000 && n <= 1050), 1'b1);
        chk_str("t1_line", rx_str(rx_q.size()), "pc=00400010 ir=8d080004\r\n");

        // Overflow: eight back-to-back records into a 4-deep FIFO
        rx_q.delete();
        for (int i = 0; i < 8; i++) send(32'h00400000 + 32'(i * 4), 32'h11110000 + 32'(i));
        chk_bit("t2_overflow_set", overflow, 1'b1);
        wait_idle("t2_drain_timeout", 8000);
        exp = {"pc=00400000 ir=11110000\r\n", "pc=00400004 ir=11110001\r\n",
               "pc=00400008 ir=11110002\r\n", "pc=0040000c ir=11110003\r\n",
               "pc=00400010 ir=11110004\r\n"};
        chk_str("t2_lines", rx_str(rx_q.size()), exp);
        chk_int("t2_char_count", rx_q.size(), 125);
        chk_bit("t2_overflow_sticky", overflow, 1'b1);

        // Reset during the third data bit of the first character
        rx_q.delete();
        send(32'h00400020, 32'h8d080004);
        repeat (15) @(negedge clk);
        chk_bit("t3_txd_data2", uart_txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_bit("t3_txd_forced", uart_txd, 1'b1);
        chk_bit("t3_busy", busy, 1'b0);
        chk_bit("t3_overflow", overflow, 1'b0);
        chk_bit("t3_halt", halt, 1'b0);
        chk_bit("t3_done", done, 1'b0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        rx_q.delete();
        send(32'h00400024, 32'hafbf0014);
        wait_idle("t3_after_timeout", 3000);
        chk_str("t3_line", rx_str(rx_q.size()), "pc=00400024 ir=afbf0014\r\n");

        // Halt after six consecutive NOPs
        rx_q.delete();
        send(32'h00400100, 32'h20080001);
        send(32'h00400104, 32'h00000000);
        send(32'h00400108, 32'h00000000);
        wait_idle("t4_first_timeout", 6000);
        chk_bit("t4_no_halt_2", halt, 1'b0);
        send(32'h0040010c, 32'h00000000);
        send(32'h00400110, 32'h00000000);
        send(32'h00400114, 32'h00000000);
        chk_bit("t4_no_halt_5", halt, 1'b0);
        send(32'h00400118, 32'h00000000);
        chk_bit("t4_halt_6", halt, 1'b1);
        wait_done("t4_done_timeout", 20000);
        exp = {"pc=00400100 ir=20080001\r\n", "pc=00400104 ir=00000000\r\n",
               "pc=00400108 ir=00000000\r\n", "pc=0040010c ir=00000000\r\n",
               "pc=00400110 ir=00000000\r\n", "pc=00400114 ir=00000000\r\n",
               "pc=00400118 ir=00000000\r\n", "halt!\r\n"};
        chk_str("t4_text", rx_str(exp.len()), exp);
`ifndef MIPS_TRACE_CYCLE_EN
        chk_int("t4_char_count", rx_q.size(), 182);
`endif
        rx_q.delete();
        send(32'h00400200, 32'h12345678);
        repeat (300) @(negedge clk);
        chk_int("t4_ignored_chars", rx_q.size(), 0);
        chk_bit("t4_ignored_busy", busy, 1'b0);
        chk_bit("t4_done_sticky", done, 1'b1);

        // Halt on misaligned pc
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("t5_done_cleared", done, 1'b0);
        chk_bit("t5_halt_cleared", halt, 1'b0);
        rx_q.delete();
        send(32'h00400002, 32'h3c1d7fff);
        chk_bit("t5_halt", halt, 1'b1);
        wait_done("t5_done_timeout", 5000);
        exp = "pc=00400002 ir=3c1d7fff\r\nhalt!\r\n";
        chk_str("t5_text", rx_str(exp.len()), exp);

`ifdef MIPS_TRACE_CYCLE_EN
        // Cycle count frozen at the halting edge, 100 edges after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        repeat (99) @(negedge clk);
        send(32'h00400002, 32'h00000001);
        wait_done("t6_done_timeout", 5000);
        exp = "pc=00400002 ir=00000001\r\nhalt!\r\ncycle=00000064\r\n";
        chk_str("t6_text", rx_str(rx_q.size()), exp);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
